// File: rtl/ram_burst_reader.sv
// Burst reader for a registered-output dual-port RAM: issues up to two outstanding reads
// and streams the words through a 2-entry skid FIFO with valid/ready flow control.
//
// state  | meaning
// IDLE   | waiting for start; no reads, no output
// READ   | issuing reads while fewer than length have been issued
// DRAIN  | all reads issued, waiting for downstream to accept remaining beats
// FINISH | one-cycle done pulse, then back to IDLE
module ram_burst_reader #(
  parameter int ram_width = 8,
  parameter int addr_size = 4,
  parameter int ram_depth = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [addr_size-1:0] base_addr,
  input  logic [addr_size:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic                 read_en,
  output logic [addr_size-1:0] rd_addr,
  input  logic [ram_width-1:0] ram_data,
  output logic [ram_width-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  localparam logic [addr_size:0] depth_w = (addr_size + 1)'(ram_depth);

  state_t               state;
  logic [addr_size-1:0] base_r;
  logic [addr_size:0]   len_r;
  logic [addr_size:0]   issued;
  logic [addr_size:0]   accepted;
  logic [addr_size:0]   addr_sum;
  logic [1:0]           count;
  logic                 inflight;
  logic [ram_width-1:0] buf0;
  logic [ram_width-1:0] buf1;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // At most two words may be outstanding (buffered plus the one the RAM is returning).
  assign read_en   = (state == READ) && (issued < len_r) &&
                     ((count == 2'd0) || ((count == 2'd1) && !inflight));
  assign addr_sum  = {1'b0, base_r} + issued;
  assign rd_addr   = addr_size'((addr_sum >= depth_w) ? addr_sum - depth_w : addr_sum);

  // The word returning from the RAM is presented directly when the FIFO is empty.
  assign out_valid = (count != 2'd0) || inflight;
  assign out_data  = (count != 2'd0) ? buf0 : (inflight ? ram_data : '0);
  assign accept    = out_valid && out_ready;
  assign push      = inflight && !(accept && (count == 2'd0));
  assign pop       = accept && (count != 2'd0);

  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_r   <= '0;
      len_r    <= '0;
      issued   <= '0;
      accepted <= '0;
      count    <= '0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= read_en;
      if (read_en) issued <= issued + 1'b1;
      if (accept) accepted <= accepted + 1'b1;

      if (push && pop) begin
        if (count == 2'd1) begin
          buf0 <= ram_data;
        end else begin
          buf0 <= buf1;
          buf1 <= ram_data;
        end
      end else if (push) begin
        if (count == 2'd0) buf0 <= ram_data;
        else buf1 <= ram_data;
        count <= count + 2'd1;
      end else if (pop) begin
        buf0  <= buf1;
        count <= count - 2'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            base_r   <= base_addr;
            len_r    <= length;
            issued   <= '0;
            accepted <= '0;
            state    <= (length == '0) ? FINISH : READ;
          end
        end
        READ: begin
          if (read_en && ((issued + 1'b1) == len_r)) state <= DRAIN;
        end
        DRAIN: begin
          if (accept && ((accepted + 1'b1) == len_r)) state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural registered-read RAM (mem[i] = i + 8'h10).
module tb_ram_burst_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;
  logic       read_en;
  logic [3:0] rd_addr;
  logic [7:0] ram_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int checks   = 0;
  int failures = 0;

  ram_burst_reader #(.ram_width(8), .addr_size(4), .ram_depth(16)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .read_en(read_en), .rd_addr(rd_addr), .ram_data(ram_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i + 8'h10);
  initial ram_data = 8'h00;
  always @(posedge clk) if (read_en) ram_data <= mem[rd_addr];

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         period;
    int         phase;
    int         poke_t;
    int         exp_done;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nrd = 0, nacc = 0, seen_done = 0, done_t = 0;
    int first_d = 0, last_d = 0;
    bit prev_stall = 0;
    logic [7:0] held = 8'h00;
    @(negedge clk);
    base_addr = v.base; length = v.len; start = 1'b1; out_ready = 1'b0;
    for (int t = 1; t <= 64; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (v.poke_t != 0 && t == v.poke_t) begin
        start = 1'b1; base_addr = 4'd9; length = 5'd2;
      end
      if (v.poke_t != 0 && t == v.poke_t + 1) start = 1'b0;
      out_ready = ((t + v.phase) % v.period) == 0;
      #1;
      if (v.len != 0 && t == 1) check($sformatf("v%0d first_read_en", idx), int'(read_en), 1);
      if (v.len != 0 && t == 2) check($sformatf("v%0d first_valid", idx), int'(out_valid), 1);
      if (read_en) begin
        check($sformatf("v%0d rd_addr%0d", idx, nrd), int'(rd_addr), (int'(v.base) + nrd) % 16);
        nrd++;
      end
      if (prev_stall) begin
        check($sformatf("v%0d stall_valid", idx), int'(out_valid), 1);
        check($sformatf("v%0d stall_data", idx), int'(out_data), int'(held));
      end
      if (out_valid && out_ready) begin
        check($sformatf("v%0d beat%0d", idx, nacc), int'(out_data), 8'h10 + (int'(v.base) + nacc) % 16);
        if (nacc == 0) first_d = int'(out_data);
        last_d = int'(out_data);
        nacc++;
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (done) begin
        seen_done = 1; done_t = t;
        check($sformatf("v%0d fin_busy", idx), int'(busy), 0);
        check($sformatf("v%0d fin_read_en", idx), int'(read_en), 0);
        check($sformatf("v%0d fin_valid", idx), int'(out_valid), 0);
        break;
      end
      check($sformatf("v%0d busy", idx), int'(busy), 1);
    end
    check($sformatf("v%0d done_seen", idx), seen_done, 1);
    check($sformatf("v%0d done_cycle", idx), done_t, v.exp_done);
    check($sformatf("v%0d reads", idx), nrd, int'(v.len));
    check($sformatf("v%0d beats", idx), nacc, int'(v.len));
    if (v.len != 0) begin
      check($sformatf("v%0d first_data", idx), first_d, int'(v.exp_first));
      check($sformatf("v%0d last_data", idx), last_d, int'(v.exp_last));
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check($sformatf("v%0d done_once", idx), int'(done), 0);
    check($sformatf("v%0d idle_busy", idx), int'(busy), 0);
    check($sformatf("v%0d idle_valid", idx), int'(out_valid), 0);
  endtask

  initial begin
    //          base   len    per ph poke done first  last
    vecs[0] = '{4'd2,  5'd4,  1, 0, 0, 6,  8'h12, 8'h15};
    vecs[1] = '{4'd14, 5'd4,  1, 0, 0, 6,  8'h1E, 8'h11};
    vecs[2] = '{4'd0,  5'd6,  3, 2, 0, 20, 8'h10, 8'h15};
    vecs[3] = '{4'd5,  5'd0,  1, 0, 0, 1,  8'h00, 8'h00};
    vecs[4] = '{4'd9,  5'd16, 1, 0, 0, 18, 8'h19, 8'h18};
    vecs[5] = '{4'd4,  5'd3,  2, 0, 0, 7,  8'h14, 8'h16};
    vecs[6] = '{4'd3,  5'd5,  1, 0, 2, 7,  8'h13, 8'h17};

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_read_en", int'(read_en), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_out_data", int'(out_data), 0);

    // reset wins over a simultaneous start
    start = 1'b1; base_addr = 4'd3; length = 5'd4;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    #1;
    check("rst_prio_busy", int'(busy), 0);
    check("rst_prio_read_en", int'(read_en), 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // reset during the second beat of an 8-beat burst
    @(negedge clk);
    base_addr = 4'd0; length = 5'd8; start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check("mid_pre_valid", int'(out_valid), 1);
    check("mid_pre_data", int'(out_data), 8'h11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_valid", int'(out_valid), 0);
    check("mid_done", int'(done), 0);
    check("mid_out_data", int'(out_data), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("mid_quiet_done%0d", k), int'(done), 0);
      check($sformatf("mid_quiet_valid%0d", k), int'(out_valid), 0);
    end
    run_vec(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
